// File: rtl/hopfield_controller_pkg.sv
// Shared constants for the Hopfield PU controller: FSM state codes and
// a-register input select values.
package hopfield_controller_pkg;

   localparam int STATE_W = 4;

   localparam logic [3:0] ST_IDLE  = 4'd0;
   localparam logic [3:0] ST_INIT  = 4'd1;
   localparam logic [3:0] ST_LOAD0 = 4'd2;
   localparam logic [3:0] ST_LOAD1 = 4'd3;
   localparam logic [3:0] ST_LOAD2 = 4'd4;
   localparam logic [3:0] ST_LOAD3 = 4'd5;
   localparam logic [3:0] ST_MULT  = 4'd6;
   localparam logic [3:0] ST_ADD   = 4'd7;
   localparam logic [3:0] ST_WB    = 4'd8;
   localparam logic [3:0] ST_CHECK = 4'd9;
   localparam logic [3:0] ST_DONE  = 4'd10;

   // a_muxs select: 1 loads the a-registers from memory, 0 from PU new_value
   localparam logic SEL_MEM = 1'b1;
   localparam logic SEL_PU  = 1'b0;

endpackage

// File: rtl/hopfield_controller_iter_counter.sv
// Saturating iteration counter with synchronous clear.
module iter_counter #(
   parameter int ITER_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              inc,
   output logic [ITER_W-1:0] count
);

   localparam logic [ITER_W-1:0] ITER_ONE = ITER_W'(1);

   // Count completed writebacks; stick at all-ones instead of wrapping
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + ITER_ONE;
      end
   end

endmodule

// File: rtl/hopfield_controller.sv
// Moore FSM sequencing the 4-neuron PU datapath: load four X words from
// memory, iterate mult/add/writeback until convergence or the iteration cap,
// then present memory word 0 with done asserted.
module hopfield_controller
   import hopfield_controller_pkg::*;
#(
   parameter int ITER_W   = 8,
   parameter int MAX_ITER = 100
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              end_signal,
   output logic [1:0]        addr_mux,
   output logic              addr_rst,
   output logic              addr_cnt_en,
   output logic              addr_set,
   output logic              mem_r_en,
   output logic              a_muxs,
   output logic              a0_reg_en,
   output logic              a1_reg_en,
   output logic              a2_reg_en,
   output logic              a3_reg_en,
   output logic              pu_mult_regs_en,
   output logic              pu_add_regs_en,
   output logic              done,
   output logic              busy,
   output logic              timeout,
   output logic [ITER_W-1:0] iter_count
);

   localparam logic              CAP_EN  = (MAX_ITER != 0);
   localparam logic [ITER_W-1:0] CAP_VAL = ITER_W'(MAX_ITER);

   logic [STATE_W-1:0] state;
   logic [STATE_W-1:0] state_nxt;
   logic [3:0]         a_reg_en;
   logic               cap_hit;

   // The counter set path is never used, so its select and load stay idle
   assign addr_mux = 2'b00;
   assign addr_set = 1'b0;

   assign a0_reg_en = a_reg_en[0];
   assign a1_reg_en = a_reg_en[1];
   assign a2_reg_en = a_reg_en[2];
   assign a3_reg_en = a_reg_en[3];

   // iter_count already includes the WB of this iteration when CHECK looks at it
   assign cap_hit = CAP_EN && (iter_count == CAP_VAL);

   // Next-state logic; start is only looked at in IDLE and DONE
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_INIT;
         ST_INIT:  state_nxt = ST_LOAD0;
         ST_LOAD0: state_nxt = ST_LOAD1;
         ST_LOAD1: state_nxt = ST_LOAD2;
         ST_LOAD2: state_nxt = ST_LOAD3;
         ST_LOAD3: state_nxt = ST_MULT;
         ST_MULT:  state_nxt = ST_ADD;
         ST_ADD:   state_nxt = ST_WB;
         ST_WB:    state_nxt = ST_CHECK;
         ST_CHECK: begin
            if (end_signal || cap_hit) state_nxt = ST_DONE;
            else                       state_nxt = ST_MULT;
         end
         ST_DONE:  if (!start) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // State register; reset aborts any run back to IDLE
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Timeout flag: cleared at INIT, decided at the final CHECK, end_signal wins
   always_ff @(posedge clk) begin
      if (rst) begin
         timeout <= 1'b0;
      end else if (state == ST_INIT) begin
         timeout <= 1'b0;
      end else if (state == ST_CHECK) begin
         if (end_signal)   timeout <= 1'b0;
         else if (cap_hit) timeout <= 1'b1;
      end
   end

   iter_counter #(
      .ITER_W (ITER_W)
   ) u_iter_counter (
      .clk   (clk),
      .rst   (rst),
      .clr   (state == ST_INIT),
      .inc   (state == ST_WB),
      .count (iter_count)
   );

   // Moore output decode; everything not named for a state is 0
   always_comb begin
      addr_rst        = 1'b0;
      addr_cnt_en     = 1'b0;
      mem_r_en        = 1'b0;
      a_muxs          = SEL_PU;
      a_reg_en        = 4'b0000;
      pu_mult_regs_en = 1'b0;
      pu_add_regs_en  = 1'b0;
      done            = 1'b0;
      busy            = 1'b0;
      case (state)
         ST_INIT: begin
            addr_rst = 1'b1;
            busy     = 1'b1;
         end
         ST_LOAD0, ST_LOAD1, ST_LOAD2, ST_LOAD3: begin
            mem_r_en    = 1'b1;
            a_muxs      = SEL_MEM;
            addr_cnt_en = 1'b1;
            busy        = 1'b1;
            case (state)
               ST_LOAD0: a_reg_en = 4'b0001;
               ST_LOAD1: a_reg_en = 4'b0010;
               ST_LOAD2: a_reg_en = 4'b0100;
               default:  a_reg_en = 4'b1000;
            endcase
         end
         ST_MULT: begin
            pu_mult_regs_en = 1'b1;
            busy            = 1'b1;
         end
         ST_ADD: begin
            pu_add_regs_en = 1'b1;
            busy           = 1'b1;
         end
         ST_WB: begin
            a_muxs   = SEL_PU;
            a_reg_en = 4'b1111;
            busy     = 1'b1;
         end
         ST_CHECK: begin
            busy = 1'b1;
         end
         ST_DONE: begin
            done     = 1'b1;
            mem_r_en = 1'b1;
            addr_rst = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_hopfield_controller.sv
// Self-checking bench for hopfield_controller: each run is predicted as a
// cycle timeline (INIT, four loads, N four-cycle iterations, DONE hold)
// derived from the end_signal values presented at each iteration's check.
module tb_hopfield_controller;

   localparam int ITER_W = 8;
   localparam int MAX_IT = 5;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              end_signal = 1'b0;
   logic [1:0]        addr_mux;
   logic              addr_rst, addr_cnt_en, addr_set, mem_r_en, a_muxs;
   logic              a0_reg_en, a1_reg_en, a2_reg_en, a3_reg_en;
   logic              pu_mult_regs_en, pu_add_regs_en, done, busy, timeout;
   logic [ITER_W-1:0] iter_count;

   int                n_tests = 0;
   int                n_fail  = 0;
   int                prev_iter;
   logic              prev_to;

   hopfield_controller #(
      .ITER_W   (ITER_W),
      .MAX_ITER (MAX_IT)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .end_signal      (end_signal),
      .addr_mux        (addr_mux),
      .addr_rst        (addr_rst),
      .addr_cnt_en     (addr_cnt_en),
      .addr_set        (addr_set),
      .mem_r_en        (mem_r_en),
      .a_muxs          (a_muxs),
      .a0_reg_en       (a0_reg_en),
      .a1_reg_en       (a1_reg_en),
      .a2_reg_en       (a2_reg_en),
      .a3_reg_en       (a3_reg_en),
      .pu_mult_regs_en (pu_mult_regs_en),
      .pu_add_regs_en  (pu_add_regs_en),
      .done            (done),
      .busy            (busy),
      .timeout         (timeout),
      .iter_count      (iter_count)
   );

   always #5 clk = ~clk;

   logic [14:0] obs;
   assign obs = {addr_mux, addr_rst, addr_cnt_en, addr_set, mem_r_en, a_muxs,
                 a0_reg_en, a1_reg_en, a2_reg_en, a3_reg_en,
                 pu_mult_regs_en, pu_add_regs_en, done, busy};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected control word for cycle k of a run (k=0 is the IDLE cycle in
   // which start is raised); kd is the first DONE cycle, hold the extra
   // DONE cycles while start stays high.
   function automatic logic [14:0] exp_vec(input int k, input int kd, input int hold);
      logic       ar, ace, mre, am, me, ad, dn, by;
      logic [3:0] ae;
      int         p;
      ar = 0; ace = 0; mre = 0; am = 0; me = 0; ad = 0; dn = 0; by = 0; ae = 4'b0000;
      if (k == 1) begin
         ar = 1; by = 1;
      end else if (k >= 2 && k <= 5) begin
         mre = 1; am = 1; ace = 1; by = 1;
         ae[k-2] = 1'b1;
      end else if (k >= 6 && k < kd) begin
         by = 1;
         p  = (k - 6) % 4;
         if (p == 0) me = 1;
         if (p == 1) ad = 1;
         if (p == 2) ae = 4'b1111;
      end else if (k >= kd && k <= kd + hold) begin
         dn = 1; mre = 1; ar = 1;
      end
      return {2'b00, ar, ace, 1'b0, mre, am, ae[0], ae[1], ae[2], ae[3], me, ad, dn, by};
   endfunction

   // mode 0: random end_signal; 1: converge at 1st check; 2: converge at 3rd;
   // 3: never converge (cap); 4: converge exactly at the cap check.
   // abort_at > 0 raises rst during that cycle of the run.
   task automatic run_one(input int mode, input int hold, input int abort_at);
      logic eb [0:63];
      int   n, kd, last, exp_it;
      logic exp_to, cur_to;
      for (int i = 0; i < 64; i++) begin
         if (mode == 0) eb[i] = ($urandom_range(0, 3) == 0);
         else           eb[i] = $urandom_range(0, 1) == 1;
      end
      if (mode != 0) begin
         for (int i = 1; i <= MAX_IT; i++) begin
            eb[5+4*i] = (mode == 1) ? 1'b1 :
                        (mode == 2) ? (i == 3) :
                        (mode == 4) ? (i == MAX_IT) : 1'b0;
         end
      end
      n = 0;
      exp_to = 1'b0;
      for (int i = 1; i <= MAX_IT && n == 0; i++) begin
         if (eb[5+4*i]) n = i;
         else if (i == MAX_IT) begin
            n = i;
            exp_to = 1'b1;
         end
      end
      kd   = 6 + 4 * n;
      last = kd + hold + 1;

      @(posedge clk); #1;
      start = 1'b1;
      end_signal = eb[0];
      @(negedge clk);
      chk("idle_vec", 32'(obs), 32'(exp_vec(0, kd, hold)));
      chk("idle_iter", 32'(iter_count), 32'(prev_iter));
      chk("idle_to", 32'(timeout), 32'(prev_to));

      for (int k = 1; k <= last; k++) begin
         @(posedge clk); #1;
         end_signal = eb[k];
         if (k < kd) start = ($urandom_range(0, 1) == 1);
         else        start = (k < kd + hold);
         if (k == abort_at) rst = 1'b1;
         @(negedge clk);
         if (k <= 1) begin
            exp_it = prev_iter;
            cur_to = prev_to;
         end else begin
            exp_it = 0;
            for (int i = 1; i <= n; i++) if (4 + 4 * i < k) exp_it++;
            cur_to = (k >= kd) ? exp_to : 1'b0;
         end
         chk($sformatf("vec m%0d k%0d", mode, k), 32'(obs), 32'(exp_vec(k, kd, hold)));
         chk($sformatf("iter m%0d k%0d", mode, k), 32'(iter_count), 32'(exp_it));
         chk($sformatf("to m%0d k%0d", mode, k), 32'(timeout), 32'(cur_to));
         if (k == abort_at) begin
            @(posedge clk); #1;
            rst = 1'b0;
            start = 1'b0;
            @(negedge clk);
            chk("abort_vec", 32'(obs), 32'd0);
            chk("abort_iter", 32'(iter_count), 32'd0);
            chk("abort_to", 32'(timeout), 32'd0);
            prev_iter = 0;
            prev_to = 1'b0;
            return;
         end
      end
      prev_iter = n;
      prev_to = exp_to;
   endtask

   initial begin
      prev_iter = 0;
      prev_to = 1'b0;
      rst = 1'b1;
      start = 1'b0;
      end_signal = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_vec", 32'(obs), 32'd0);
      chk("reset_iter", 32'(iter_count), 32'd0);
      chk("reset_to", 32'(timeout), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      run_one(1, 2, 0);
      run_one(2, 0, 0);
      run_one(3, 1, 0);
      run_one(1, 0, 0);
      run_one(3, 0, 11);
      run_one(1, 3, 0);
      run_one(4, 1, 0);
      for (int r = 0; r < 20; r++) begin
         run_one(0, int'($urandom_range(0, 3)), 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
